// File: rtl/secure_tx_scheduler.sv
// secure_tx_scheduler: two-requester round-robin transmit scheduler.
// Each payload is XOR-masked with one 32-bit word of a loaded 128-bit key.
// The key word rotates through the key with every completed transfer.
// Cleartext payload and raw key bits never reach an output.
module secure_tx_scheduler (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_valid,
  input  logic [1:0]   req,
  input  logic [31:0]  data0,
  input  logic [31:0]  data1,
  output logic [1:0]   grant,
  output logic         err_nokey,
  output logic [31:0]  tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_src,
  output logic [15:0]  tx_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MASK = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state, state_d;

  logic [127:0]  key_q, key_d;
  logic          key_valid_d;
  logic [1:0]    word_idx, word_idx_d;
  logic [15:0]   tx_count_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   tx_data_d;
  logic          tx_valid_d;
  logic          tx_src_d;
  logic [1:0]    grant_d;
  logic          err_nokey_d;
  logic          last_served, last_served_d;

  logic          winner;
  logic [31:0]   key_word;

  // Round-robin pick: a lone requester wins, otherwise whoever was not served last.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = ~last_served;
    else              winner = req[1];
  end

  assign key_word = key_q[{word_idx, 5'b00000} +: 32];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and next-value logic for every register in the block.
  always_comb begin
    // NOTE: every target gets a default first, so no path can leave a value
    // unassigned and infer a latch; defaults hold state, pulses default low.
    state_d       = state;
    key_d         = key_q;
    key_valid_d   = key_valid;
    word_idx_d    = word_idx;
    tx_count_d    = tx_count;
    buf_d         = buf_q;
    tx_data_d     = tx_data;
    tx_valid_d    = tx_valid;
    tx_src_d      = tx_src;
    last_served_d = last_served;
    grant_d       = 2'b00;
    err_nokey_d   = 1'b0;

    case (state)
      IDLE: begin
        if (key_load) begin
          // Key loading outranks any pending request.
          key_d       = key_in;
          key_valid_d = 1'b1;
        end else if (req != 2'b00) begin
          if (!key_valid) begin
            err_nokey_d = 1'b1;
          end else begin
            buf_d         = winner ? data1 : data0;
            grant_d       = winner ? 2'b10 : 2'b01;
            tx_src_d      = winner;
            last_served_d = winner;
            state_d       = MASK;
          end
        end
      end

      MASK: begin
        tx_data_d  = buf_q ^ key_word;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        if (tx_ready) begin
          tx_data_d  = 32'h0;
          tx_valid_d = 1'b0;
          buf_d      = 32'h0;
          word_idx_d = word_idx + 2'd1;
          tx_count_d = tx_count + 16'd1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the key register and payload buffer are reset too, because a
      // reset must leave no secret or cleartext behind in the block.
      key_q       <= 128'h0;
      key_valid   <= 1'b0;
      word_idx    <= 2'd0;
      tx_count    <= 16'h0;
      buf_q       <= 32'h0;
      tx_data     <= 32'h0;
      tx_valid    <= 1'b0;
      tx_src      <= 1'b0;
      grant       <= 2'b00;
      err_nokey   <= 1'b0;
      last_served <= 1'b1;
    end else begin
      key_q       <= key_d;
      key_valid   <= key_valid_d;
      word_idx    <= word_idx_d;
      tx_count    <= tx_count_d;
      buf_q       <= buf_d;
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
      tx_src      <= tx_src_d;
      grant       <= grant_d;
      err_nokey   <= err_nokey_d;
      last_served <= last_served_d;
    end
  end

endmodule

// File: tb/tb_secure_tx_scheduler.sv
// Self-checking bench for secure_tx_scheduler with a transaction-level model.
module tb_secure_tx_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_valid;
  logic [1:0]   req;
  logic [31:0]  data0, data1;
  logic [1:0]   grant;
  logic         err_nokey;
  logic [31:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_src;
  logic [15:0]  tx_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: the key, which word is next, transfers done, last winner.
  logic [127:0] m_key;
  logic         m_key_valid;
  int           m_word;
  int           m_count;
  int           m_last;

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF_FEDCBA9876543210;

  secure_tx_scheduler dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
    .key_valid(key_valid), .req(req), .data0(data0), .data1(data1),
    .grant(grant), .err_nokey(err_nokey), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_src(tx_src),
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_mask(input logic [31:0] d);
    return d ^ m_key[m_word*32 +: 32];
  endfunction

  function automatic int m_pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - m_last;
    return r[1] ? 1 : 0;
  endfunction

  // Drives one complete transfer with tx_ready high and records what the DUT shows
  // at +1 (grant), +2 (masked word) and +3 (after the handshake).
  task automatic xfer(input logic [1:0] r, input logic [31:0] d0, input logic [31:0] d1,
                      input logic junk_key,
                      output logic [1:0] g, output logic v2, output logic [31:0] td2,
                      output logic s2, output logic v3, output logic [31:0] td3,
                      output logic [15:0] cnt3);
    req = r; data0 = d0; data1 = d1; tx_ready = 1'b1;
    @(negedge clk);
    g = grant;
    req = 2'b00; data0 = $urandom; data1 = $urandom;
    if (junk_key) begin
      key_load = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    v2 = tx_valid; td2 = tx_data; s2 = tx_src;
    key_load = 1'b0;
    @(negedge clk);
    v3 = tx_valid; td3 = tx_data; cnt3 = tx_count;
  endtask

  // One transfer compared against the model, which is then advanced.
  task automatic scoreboard_transfer(input logic [1:0] r, input logic [31:0] d0,
                                     input logic [31:0] d1, input logic junk_key);
    logic [1:0] g; logic v2, s2, v3; logic [31:0] td2, td3; logic [15:0] c3;
    int w;
    logic [31:0] exp_data;
    w = m_pick(r);
    exp_data = m_mask(w == 1 ? d1 : d0);
    xfer(r, d0, d1, junk_key, g, v2, td2, s2, v3, td3, c3);
    m_last = w; m_word = (m_word + 1) % 4; m_count = (m_count + 1) % 65536;
    checks++;
    if (g !== (w == 1 ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL grant req=%b: got %b expected %b", r, g, (w == 1 ? 2'b10 : 2'b01));
    end
    checks++;
    if (v2 !== 1'b1 || td2 !== exp_data) begin
      errors++; $display("FAIL tx_data: got valid=%b data=%h expected valid=1 data=%h", v2, td2, exp_data);
    end
    checks++;
    if (s2 !== w[0]) begin
      errors++; $display("FAIL tx_src: got %b expected %0d", s2, w);
    end
    checks++;
    if (v3 !== 1'b0 || td3 !== 32'h0) begin
      errors++; $display("FAIL post_handshake: got valid=%b data=%h expected 0/0", v3, td3);
    end
    checks++;
    if (c3 !== m_count[15:0]) begin
      errors++; $display("FAIL tx_count: got %0d expected %0d", c3, m_count);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; req = 2'b00; key_load = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_key = 128'h0; m_key_valid = 1'b0; m_word = 0; m_count = 0; m_last = 1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (key_valid !== 1'b0 || grant !== 2'b00 || err_nokey !== 1'b0 || tx_data !== 32'h0 ||
        tx_valid !== 1'b0 || tx_src !== 1'b0 || tx_count !== 16'h0) begin
      errors++;
      $display("FAIL %s: got kv=%b g=%b err=%b data=%h v=%b src=%b cnt=%h expected all 0",
               name, key_valid, grant, err_nokey, tx_data, tx_valid, tx_src, tx_count);
    end
  endtask

  // Loads a key while also requesting, so the priority of key_load is exercised.
  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1; key_in = k; req = 2'b01; data0 = $urandom;
    @(negedge clk);
    key_load = 1'b0; req = 2'b00;
    m_key = k; m_key_valid = 1'b1;
    checks++;
    if (key_valid !== 1'b1 || grant !== 2'b00 || err_nokey !== 1'b0) begin
      errors++;
      $display("FAIL key_load: got kv=%b grant=%b err=%b expected kv=1 grant=00 err=0",
               key_valid, grant, err_nokey);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_all_zero("reset_state");
  endtask

  task automatic test_nokey();
    req = 2'b01; data0 = 32'h12345678;
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (err_nokey !== 1'b1 || grant !== 2'b00) begin
      errors++; $display("FAIL nokey_pulse: got err=%b grant=%b expected err=1 grant=00", err_nokey, grant);
    end
    @(negedge clk);
    checks++;
    if (err_nokey !== 1'b0 || tx_valid !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL nokey_after: got err=%b v=%b grant=%b expected 0/0/00", err_nokey, tx_valid, grant);
    end
  endtask

  task automatic test_known_vectors();
    logic [1:0] g; logic v2, s2, v3; logic [31:0] td2, td3; logic [15:0] c3;
    load_key(KEY_A);
    xfer(2'b01, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, g, v2, td2, s2, v3, td3, c3);
    checks++;
    if (g !== 2'b01 || v2 !== 1'b1 || td2 !== 32'hA8F98CFF || s2 !== 1'b0 || c3 !== 16'd1) begin
      errors++;
      $display("FAIL vector0: got g=%b v=%b data=%h src=%b cnt=%0d expected 01/1/a8f98cff/0/1",
               g, v2, td2, s2, c3);
    end
    xfer(2'b10, 32'h55555555, 32'h00000000, 1'b0, g, v2, td2, s2, v3, td3, c3);
    checks++;
    if (g !== 2'b10 || v2 !== 1'b1 || td2 !== 32'hFEDCBA98 || s2 !== 1'b1 || c3 !== 16'd2) begin
      errors++;
      $display("FAIL vector1: got g=%b v=%b data=%h src=%b cnt=%0d expected 10/1/fedcba98/1/2",
               g, v2, td2, s2, c3);
    end
    m_word = 2; m_count = 2; m_last = 1;
  endtask

  // Fresh reset so the key word index starts at 0 and the fifth transfer wraps.
  task automatic test_round_robin();
    apply_reset();
    load_key({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 5; i++)
      scoreboard_transfer(2'b11, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] d, held;
    logic [31:0] exp_data;
    int w;
    d = $urandom;
    w = m_pick(2'b01);
    exp_data = m_mask(d);
    req = 2'b01; data0 = d; tx_ready = 1'b0;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    held = tx_data;
    checks++;
    if (tx_valid !== 1'b1 || held !== exp_data) begin
      errors++; $display("FAIL stall_start: got v=%b data=%h expected 1/%h", tx_valid, held, exp_data);
    end
    req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_data || grant !== 2'b00 || tx_src !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got v=%b data=%h grant=%b src=%b expected 1/%h/00/0",
                 i, tx_valid, tx_data, grant, tx_src, exp_data);
      end
    end
    tx_ready = 1'b1;
    @(negedge clk);
    req = 2'b00;
    m_last = w; m_word = (m_word + 1) % 4; m_count = m_count + 1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0 || tx_count !== m_count[15:0]) begin
      errors++;
      $display("FAIL stall_release: got v=%b data=%h cnt=%0d expected 0/0/%0d", tx_valid, tx_data, tx_count, m_count);
    end
  endtask

  task automatic test_reset_mid_send();
    tx_ready = 1'b0;
    req = 2'b01; data0 = $urandom;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; tx_ready = 1'b1;
    m_key = 128'h0; m_key_valid = 1'b0; m_word = 0; m_count = 0; m_last = 1;
    check_all_zero("reset_in_send");
    test_nokey();
  endtask

  // Random requests and payloads, with an ignored key_load injected mid-transfer.
  task automatic test_random();
    logic [1:0] r;
    load_key({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      scoreboard_transfer(r, $urandom, $urandom, 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; key_load = 1'b0; key_in = 128'h0; req = 2'b00;
    data0 = 32'h0; data1 = 32'h0; tx_ready = 1'b1;
    test_reset();
    test_nokey();
    test_known_vectors();
    test_round_robin();
    test_backpressure();
    test_reset_mid_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secure_tx_scheduler.md
SECURE_TX_SCHEDULER -- requirements
Module: secure_tx_scheduler

Interface
REQ-001 SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have input key_load, 1 bit: request to load key_in into the key register.
REQ-004 SHALL have input key_in, 128 bits: secret key value.
REQ-005 SHALL have output key_valid, 1 bit: a key is loaded.
REQ-006 SHALL have input req, 2 bits: per-requester transmit request, level-sensitive.
REQ-007 SHALL have inputs data0 and data1, 32 bits each: cleartext payloads of requesters 0 and 1.
REQ-008 SHALL have output grant, 2 bits: one-hot, one-cycle pulse marking the payload as captured.
REQ-009 SHALL have output err_nokey, 1 bit: one-cycle pulse when a request is refused because no key is loaded.
REQ-010 SHALL have output tx_data, 32 bits: masked payload.
REQ-011 SHALL have output tx_valid, 1 bit: tx_data is valid.
REQ-012 SHALL have input tx_ready, 1 bit: sink accepts tx_data.
REQ-013 SHALL have output tx_src, 1 bit: requester index of the current tx_data.
REQ-014 SHALL have output tx_count, 16 bits: number of completed transfers, wraps 0xFFFF->0x0000.

Function
REQ-015 SHALL implement the FSM states IDLE, MASK and SEND.
REQ-016 In IDLE with key_load=1, SHALL load key_in into the 128-bit key register and set key_valid=1, with no grant that cycle (key_load has priority over req).
REQ-017 Outside IDLE, SHALL ignore key_load.
REQ-018 In IDLE with key_valid=0, key_load=0 and req!=0, SHALL pulse err_nokey the next cycle, issue no grant, and stay in IDLE.
REQ-019 In IDLE with key_valid=1, key_load=0 and req!=0, SHALL arbitrate round-robin: a single requester wins; if both request, the one not served last wins; the pointer resets to "last served = 1" so requester 0 wins first.
REQ-020 On winning in IDLE, SHALL capture the winner's data into an internal buffer, pulse grant[winner] the next cycle, latch tx_src, and go to MASK.
REQ-021 In MASK, SHALL drive tx_data = buffer XOR key word, where key word = key[32*word_idx+31 : 32*word_idx], set tx_valid=1, and go to SEND.
REQ-022 tx_valid SHALL rise exactly 2 cycles after the cycle in which the request was sampled in IDLE.
REQ-023 In SEND, SHALL hold tx_data, tx_src and tx_valid stable until tx_valid && tx_ready.
REQ-024 On the SEND handshake, the next cycle SHALL have tx_valid=0 and tx_data=0, word_idx incremented (2-bit, 3 wraps to 0), tx_count incremented, the buffer cleared to 0, and FSM in IDLE.
REQ-025 tx_data SHALL be 0 whenever tx_valid=0; cleartext payload or raw key bits SHALL never appear on any output.
REQ-026 tx_ready while tx_valid=0 SHALL have no effect.
REQ-027 Minimum spacing between transfers SHALL be 3 cycles (IDLE, MASK, SEND), with tx_ready held high.

Reset
REQ-028 With reset=1 at a clock edge, SHALL clear: key register, key_valid, word_idx, tx_count, buffer, tx_data, tx_valid, tx_src, grant, err_nokey; FSM to IDLE; arbitration pointer to its reset value.
REQ-029 Reset mid-transfer (MASK or SEND) SHALL abort the transfer without a handshake, and the key SHALL be reloaded before further grants.

Verification
REQ-030 Reset, req=2'b01 with no key -> err_nokey pulse, grant=0, tx_valid stays 0.
REQ-031 key_in=128'h0123456789ABCDEF_FEDCBA9876543210 loaded; data0=32'hDEADBEEF, req=01, tx_ready=1 -> grant=01 at +1, tx_valid at +2 with tx_data=32'hA8F98CFF, tx_src=0, tx_count=1.
REQ-032 Next transfer data1=32'h00000000, req=10 -> tx_data=32'hFEDCBA98 (word_idx=1), tx_src=1.
REQ-033 req=11 held for 4 transfers -> grants alternate 01,10,01,10; the fifth transfer uses key word 0 again (wrap).
REQ-034 tx_ready=0 for 5 cycles in SEND -> tx_data and tx_valid stable and no new grant; on tx_ready=1 -> handshake, then tx_data=0.
REQ-035 reset asserted during SEND -> next cycle all outputs 0, key_valid=0; a subsequent req produces err_nokey.
